decoder3_sel_seq: RTL and testbench
===================================

Name: decoder3_sel_seq

Overview:
- Phase sequencer that sits directly upstream of the 3-to-8 decoder brick and drives its 3-bit select `i`.
- Steps the select code through 0..LAST, holding each code for a programmable dwell, in single-sweep or continuous mode.
- Provides `sel_vld` so downstream logic can gate the one-hot decoder output.
- Reports busy/done status and a sweep counter to the control block.

Parameters:
- DWELL_W, 8, width of dwell count (cycles per phase = dwell+1)
- SWEEP_W, 8, width of saturating completed-sweep counter
- IDLE_CODE, 3'd0, select code driven while idle

Ports:
- CELCLK  input  1  clock, rising edge
- CELRST  input  1  reset, synchronous, active-high
- CELV  input  1  supply pin, connectivity only, no RTL function
- CELG  input  1  ground pin, connectivity only, no RTL function
- SUB  input  1  substrate pin, connectivity only, no RTL function
- start  input  1  begin sequence (level sampled each cycle)
- stop  input  1  graceful stop request
- abort  input  1  immediate stop
- mode_single  input  1  1 = one sweep then idle; 0 = continuous wrap
- dwell  input  DWELL_W  hold count per phase, latched at start
- last  input  3  final code of a sweep, latched at start
- i  output  3  select code to decoder `i[2:0]`
- sel_vld  output  1  `i` is an active phase
- busy  output  1  sequencer not idle
- done  output  1  one-cycle pulse on return to IDLE from RUN
- sweep_cnt  output  SWEEP_W  completed sweeps since start, saturating

Behaviour:
- Reset (CELRST=1 at edge), including mid-sequence:
  - state=IDLE, i=IDLE_CODE, sel_vld=0, busy=0, done=0, sweep_cnt=0.
  - Latched dwell/last are cleared to 0.
  - Reset overrides all other inputs.
- States: IDLE, RUN (plus GAP with the optional feature).
- IDLE:
  - i=IDLE_CODE, sel_vld=0, busy=0.
  - start=1 with stop=0 and abort=0: latch dwell and last, phase=0, cnt=dwell, sweep_cnt=0, go to RUN.
  - start together with stop or abort: stay in IDLE, no done pulse.
- RUN:
  - i=phase, sel_vld=1, busy=1.
  - First RUN cycle is the cycle after start was sampled, so latency from start to first valid code is 1 cycle.
  - cnt decrements each cycle. Each phase lasts exactly dwell+1 cycles; dwell=0 gives 1 cycle per phase.
- Phase end (cnt==0), in priority order:
  1. Pending stop → IDLE, done=1.
  2. phase==last and mode_single=1 → sweep_cnt+1, IDLE, done=1.
  3. phase==last and mode_single=0 → sweep_cnt+1, phase=0, reload cnt.
  4. Otherwise → phase+1, reload cnt.
- last=0: every sweep is the single code 0.
- stop: a pulse during RUN sets a sticky stop_pend, honoured at the end of the current phase. The phase is never truncated.
- abort in RUN: next cycle is IDLE with done=1; the current phase is truncated and stop_pend is cleared.
- start while busy: ignored. Changes to dwell, last or mode_single while busy: mode_single is sampled live; dwell and last take effect only at the next start.
- sweep_cnt saturates at all-ones and is cleared at each accepted start.
- done is registered: asserted in the first IDLE cycle, deasserted the following cycle.
- Outputs change only on CELCLK rising edges. No combinational input-to-output paths.

Optional Feature:
- Macro: DECODER3_SEQ_BBM_EN (break-before-make).
- Defined:
  - Each phase-to-phase transition inside RUN, including the wrap last→0, inserts one GAP cycle.
  - GAP: i already shows the new code, sel_vld=0, busy=1.
  - Next cycle returns to RUN with sel_vld=1.
  - GAP is not inserted before the first phase or on exit to IDLE.
  - abort during GAP → IDLE with done=1.
- Undefined: no GAP state; sel_vld stays 1 continuously through RUN.

Test Plan:
- Reset, then start, mode_single=1, dwell=1, last=3 → i = 0,0,1,1,2,2,3,3 with sel_vld=1 for 8 cycles, then i=0, sel_vld=0, done pulsed once, sweep_cnt=1.
- Continuous mode, dwell=0, last=7, run 20 cycles → i = 0..7,0..7,0..3; sweep_cnt increments on cycles 8 and 16 (values 1, 2).
- dwell=3, last=5, stop pulsed at cycle 2 of phase 2 → phase 2 holds all 4 cycles, then IDLE with done, phase 3 never appears.
- abort in the 2nd cycle of phase 1 → next cycle IDLE, i=IDLE_CODE, done=1. start and stop together in IDLE → stays IDLE, done=0.
- CELRST asserted mid-RUN at phase 4 → next cycle all outputs at reset values; a new start restarts at phase 0 with freshly latched dwell.
- With DECODER3_SEQ_BBM_EN, dwell=0, last=2, single sweep → i/sel_vld = 0/1, 1/0, 1/1, 2/0, 2/1, then IDLE with done.

Source files
------------

// File: rtl/decoder3_sel_seq.sv
// decoder3_sel_seq: phase sequencer driving the 3-bit select of a 3-to-8 decoder.
// It steps the select code through 0..last and holds each code for dwell+1 cycles.
// It runs either one sweep or wraps continuously.
// It reports busy, a one-cycle done pulse and a saturating sweep counter.
// Optional break-before-make: define DECODER3_SEQ_BBM_EN to insert a one-cycle
// GAP (sel_vld low, new code already on i) between consecutive phases.
module decoder3_sel_seq #(
    parameter int          DWELL_W   = 8,
    parameter int          SWEEP_W   = 8,
    parameter logic [2:0]  IDLE_CODE = 3'd0
) (
    input  logic               CELCLK,
    input  logic               CELRST,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    input  logic               start,
    input  logic               stop,
    input  logic               abort,
    input  logic               mode_single,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [2:0]         last,
    output logic [2:0]         i,
    output logic               sel_vld,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Power/substrate pins exist for connectivity only.
    logic w_unused_pins;
    assign w_unused_pins = CELV ^ CELG ^ SUB;

    state_t             r_state,     w_nxt_state;
    logic [2:0]         r_phase,     w_nxt_phase;
    logic [DWELL_W-1:0] r_cnt,       w_nxt_cnt;
    logic [DWELL_W-1:0] r_dwell,     w_nxt_dwell;
    logic [2:0]         r_last,      w_nxt_last;
    logic               r_stop_pend, w_nxt_stop_pend;
    logic               r_done,      w_nxt_done;
    logic [SWEEP_W-1:0] r_sweep,     w_nxt_sweep;

    logic               w_stop_req;
    logic [SWEEP_W-1:0] w_sweep_inc;
    logic               w_start_ok;

    // A live stop on the final cycle of a phase counts as pending.
    assign w_stop_req  = r_stop_pend | stop;
    assign w_sweep_inc = (r_sweep == {SWEEP_W{1'b1}}) ? r_sweep : r_sweep + 1'b1;
    assign w_start_ok  = start & ~stop & ~abort;

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            r_state     <= S_IDLE;
            r_phase     <= 3'd0;
            r_cnt       <= '0;
            r_dwell     <= '0;
            r_last      <= 3'd0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_sweep     <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_phase     <= w_nxt_phase;
            r_cnt       <= w_nxt_cnt;
            r_dwell     <= w_nxt_dwell;
            r_last      <= w_nxt_last;
            r_stop_pend <= w_nxt_stop_pend;
            r_done      <= w_nxt_done;
            r_sweep     <= w_nxt_sweep;
        end
    end

    // Next-state logic: start acceptance, dwell countdown, phase-end priorities, abort.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_phase     = r_phase;
        w_nxt_cnt       = r_cnt;
        w_nxt_dwell     = r_dwell;
        w_nxt_last      = r_last;
        w_nxt_stop_pend = r_stop_pend;
        w_nxt_done      = 1'b0;
        w_nxt_sweep     = r_sweep;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_nxt_dwell     = dwell;
                    w_nxt_last      = last;
                    w_nxt_phase     = 3'd0;
                    w_nxt_cnt       = dwell;
                    w_nxt_sweep     = '0;
                    w_nxt_stop_pend = 1'b0;
                    w_nxt_state     = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_nxt_state     = S_IDLE;
                    w_nxt_done      = 1'b1;
                    w_nxt_stop_pend = 1'b0;
                end else if (r_cnt == '0) begin
                    if (w_stop_req) begin
                        w_nxt_state     = S_IDLE;
                        w_nxt_done      = 1'b1;
                        w_nxt_stop_pend = 1'b0;
                    end else if (r_phase == r_last && mode_single) begin
                        w_nxt_sweep = w_sweep_inc;
                        w_nxt_state = S_IDLE;
                        w_nxt_done  = 1'b1;
                    end else begin
                        if (r_phase == r_last) begin
                            w_nxt_sweep = w_sweep_inc;
                            w_nxt_phase = 3'd0;
                        end else begin
                            w_nxt_phase = r_phase + 3'd1;
                        end
                        w_nxt_cnt = r_dwell;
`ifdef DECODER3_SEQ_BBM_EN
                        w_nxt_state = S_GAP;
`endif
                    end
                end else begin
                    w_nxt_cnt       = r_cnt - 1'b1;
                    w_nxt_stop_pend = w_stop_req;
                end
            end
`ifdef DECODER3_SEQ_BBM_EN
            S_GAP: begin
                if (abort) begin
                    w_nxt_state     = S_IDLE;
                    w_nxt_done      = 1'b1;
                    w_nxt_stop_pend = 1'b0;
                end else begin
                    w_nxt_state     = S_RUN;
                    w_nxt_stop_pend = w_stop_req;
                end
            end
`endif
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so there is no input-to-output path.
    assign i         = (r_state == S_IDLE) ? IDLE_CODE : r_phase;
    assign sel_vld   = (r_state == S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign sweep_cnt = r_sweep;

endmodule

// File: tb/tb_decoder3_sel_seq.sv
// Directed bench for decoder3_sel_seq.
// Every step queues its expected outputs.
// After each clock edge the queued entry is popped and compared.
module tb_decoder3_sel_seq;

    logic       CELCLK = 1'b0;
    logic       CELRST, CELV, CELG, SUB;
    logic       start, stop, abort, mode_single;
    logic [7:0] dwell;
    logic [2:0] last;
    logic [2:0] i;
    logic       sel_vld, busy, done;
    logic [7:0] sweep_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] ei;
        logic       ev, eb, ed;
        logic [7:0] esw;
    } exp_t;

    exp_t sb[$];

    decoder3_sel_seq #(.DWELL_W(8), .SWEEP_W(8), .IDLE_CODE(3'd0)) dut (
        .CELCLK(CELCLK), .CELRST(CELRST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .start(start), .stop(stop), .abort(abort), .mode_single(mode_single),
        .dwell(dwell), .last(last),
        .i(i), .sel_vld(sel_vld), .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
    );

    always #5 CELCLK = ~CELCLK;

    // Queue the expectation, clock once, then pop and compare 1 time unit after the edge.
    task automatic tick(input string tag, input logic [2:0] ei, input logic ev,
                        input logic eb, input logic ed, input logic [7:0] esw);
        exp_t e;
        e.tag = tag; e.ei = ei; e.ev = ev; e.eb = eb; e.ed = ed; e.esw = esw;
        sb.push_back(e);
        @(posedge CELCLK);
        #1;
        e = sb.pop_front();
        checks++;
        assert (i === e.ei) else begin
            errors++; $error("FAIL %s i: got %0d expected %0d", e.tag, i, e.ei);
        end
        checks++;
        assert (sel_vld === e.ev) else begin
            errors++; $error("FAIL %s sel_vld: got %0b expected %0b", e.tag, sel_vld, e.ev);
        end
        checks++;
        assert (busy === e.eb) else begin
            errors++; $error("FAIL %s busy: got %0b expected %0b", e.tag, busy, e.eb);
        end
        checks++;
        assert (done === e.ed) else begin
            errors++; $error("FAIL %s done: got %0b expected %0b", e.tag, done, e.ed);
        end
        checks++;
        assert (sweep_cnt === e.esw) else begin
            errors++; $error("FAIL %s sweep_cnt: got %0d expected %0d", e.tag, sweep_cnt, e.esw);
        end
    endtask

    initial begin
        CELRST = 1'b1; CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
        start = 0; stop = 0; abort = 0; mode_single = 1; dwell = 8'd0; last = 3'd0;
        tick("reset0", 3'd0, 0, 0, 0, 8'd0);
        tick("reset1", 3'd0, 0, 0, 0, 8'd0);
        CELRST = 1'b0;
        tick("idle", 3'd0, 0, 0, 0, 8'd0);

`ifdef DECODER3_SEQ_BBM_EN
        // Break-before-make: dwell=0, last=2, single sweep.
        dwell = 8'd0; last = 3'd2; mode_single = 1; start = 1;
        tick("bbm_p0",  3'd0, 1, 1, 0, 8'd0);
        start = 0;
        tick("bbm_g1",  3'd1, 0, 1, 0, 8'd0);
        tick("bbm_p1",  3'd1, 1, 1, 0, 8'd0);
        tick("bbm_g2",  3'd2, 0, 1, 0, 8'd0);
        tick("bbm_p2",  3'd2, 1, 1, 0, 8'd0);
        tick("bbm_end", 3'd0, 0, 0, 1, 8'd1);
        tick("bbm_idl", 3'd0, 0, 0, 0, 8'd1);
`else
        // Single sweep, dwell=1, last=3; dwell is changed mid-run and must not take effect.
        dwell = 8'd1; last = 3'd3; mode_single = 1; start = 1;
        tick("s1_p0a", 3'd0, 1, 1, 0, 8'd0);
        start = 0; dwell = 8'd5; last = 3'd7;
        tick("s1_p0b", 3'd0, 1, 1, 0, 8'd0);
        for (int p = 1; p <= 3; p++) begin
            tick("s1_pa", 3'(p), 1, 1, 0, 8'd0);
            tick("s1_pb", 3'(p), 1, 1, 0, 8'd0);
        end
        tick("s1_done", 3'd0, 0, 0, 1, 8'd1);
        tick("s1_idle", 3'd0, 0, 0, 0, 8'd1);

        // Continuous, dwell=0, last=7, 20 cycles, then abort.
        dwell = 8'd0; last = 3'd7; mode_single = 0; start = 1;
        for (int k = 1; k <= 20; k++) begin
            tick("cont", 3'((k - 1) % 8), 1, 1, 0, 8'((k - 1) / 8));
            start = 0;
        end
        abort = 1;
        tick("cont_abort", 3'd0, 0, 0, 1, 8'd2);
        abort = 0;
        tick("cont_idle", 3'd0, 0, 0, 0, 8'd2);

        // Graceful stop: dwell=3, last=5, stop pulsed in cycle 2 of phase 2.
        dwell = 8'd3; last = 3'd5; mode_single = 1; start = 1;
        tick("stp_p0", 3'd0, 1, 1, 0, 8'd0);
        start = 0;
        for (int c = 0; c < 3; c++) tick("stp_p0", 3'd0, 1, 1, 0, 8'd0);
        for (int c = 0; c < 4; c++) tick("stp_p1", 3'd1, 1, 1, 0, 8'd0);
        tick("stp_p2c1", 3'd2, 1, 1, 0, 8'd0);
        tick("stp_p2c2", 3'd2, 1, 1, 0, 8'd0);
        stop = 1;
        tick("stp_p2c3", 3'd2, 1, 1, 0, 8'd0);
        stop = 0;
        tick("stp_p2c4", 3'd2, 1, 1, 0, 8'd0);
        tick("stp_done", 3'd0, 0, 0, 1, 8'd0);
        tick("stp_idle", 3'd0, 0, 0, 0, 8'd0);

        // Abort in the 2nd cycle of phase 1.
        dwell = 8'd1; last = 3'd3; mode_single = 1; start = 1;
        tick("ab_p0a", 3'd0, 1, 1, 0, 8'd0);
        start = 0;
        tick("ab_p0b", 3'd0, 1, 1, 0, 8'd0);
        tick("ab_p1a", 3'd1, 1, 1, 0, 8'd0);
        tick("ab_p1b", 3'd1, 1, 1, 0, 8'd0);
        abort = 1;
        tick("ab_done", 3'd0, 0, 0, 1, 8'd0);
        abort = 0;
        tick("ab_idle", 3'd0, 0, 0, 0, 8'd0);

        // start with stop, then start with abort: both are refused in IDLE.
        start = 1; stop = 1;
        tick("st_stop", 3'd0, 0, 0, 0, 8'd0);
        stop = 0; abort = 1;
        tick("st_abort", 3'd0, 0, 0, 0, 8'd0);
        start = 0; abort = 0;
        tick("st_idle", 3'd0, 0, 0, 0, 8'd0);

        // Reset mid-run at phase 4, then restart with a new dwell.
        dwell = 8'd0; last = 3'd7; mode_single = 0; start = 1;
        tick("rr_p0", 3'd0, 1, 1, 0, 8'd0);
        start = 0;
        for (int p = 1; p <= 4; p++) tick("rr_p", 3'(p), 1, 1, 0, 8'd0);
        CELRST = 1;
        tick("rr_reset", 3'd0, 0, 0, 0, 8'd0);
        CELRST = 0;
        dwell = 8'd2; last = 3'd1; mode_single = 1; start = 1;
        tick("rr_s_p0", 3'd0, 1, 1, 0, 8'd0);
        start = 0;
        tick("rr_s_p0", 3'd0, 1, 1, 0, 8'd0);
        tick("rr_s_p0", 3'd0, 1, 1, 0, 8'd0);
        for (int c = 0; c < 3; c++) tick("rr_s_p1", 3'd1, 1, 1, 0, 8'd0);
        tick("rr_done", 3'd0, 0, 0, 1, 8'd1);

        // last=0, single sweep: one code-0 cycle, then done.
        dwell = 8'd0; last = 3'd0; mode_single = 1; start = 1;
        tick("l0_p0", 3'd0, 1, 1, 0, 8'd0);
        start = 0;
        tick("l0_done", 3'd0, 0, 0, 1, 8'd1);

        // Sweep counter saturation: last=0, continuous, one sweep per cycle.
        mode_single = 0; start = 1;
        for (int k = 1; k <= 260; k++) begin
            tick("sat", 3'd0, 1, 1, 0, (k - 1 > 255) ? 8'd255 : 8'(k - 1));
            start = 0;
        end
        abort = 1;
        tick("sat_abort", 3'd0, 0, 0, 1, 8'd255);
        abort = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
